// File: rtl/axis_burst_framer_pkg.sv
// Shared types, widths and header layout for the ADC burst framer.
// Header word: {magic[31:24], lost_flag[23], 7'b0, seq[15:0]}.
package axis_burst_framer_pkg;

  localparam int unsigned DATA_WIDTH    = 32;
  localparam int unsigned SEQ_WIDTH     = 16;
  localparam int unsigned LOST_WIDTH    = 16;
  localparam int unsigned MAGIC_WIDTH   = 8;

  localparam int unsigned HDR_MAGIC_LSB = 24;
  localparam int unsigned HDR_LOST_BIT  = 23;
  localparam int unsigned HDR_SEQ_LSB   = 0;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BURST = 2'd1;
  localparam logic [1:0] ST_DROP  = 2'd2;

  typedef struct packed {
    logic                  last;
    logic [DATA_WIDTH-1:0] data;
  } fifo_word_t;

  localparam int unsigned FIFO_WORD_WIDTH = $bits(fifo_word_t);

  function automatic logic [DATA_WIDTH-1:0] build_header(
    input logic [MAGIC_WIDTH-1:0] magic,
    input logic                   lost,
    input logic [SEQ_WIDTH-1:0]   seq
  );
    logic [DATA_WIDTH-1:0] hdr;
    hdr = '0;
    hdr[HDR_MAGIC_LSB +: MAGIC_WIDTH] = magic;
    hdr[HDR_LOST_BIT]                 = lost;
    hdr[HDR_SEQ_LSB +: SEQ_WIDTH]     = seq;
    return hdr;
  endfunction

endpackage

// File: rtl/burst_framer_fifo.sv
// Synchronous first-word-fall-through FIFO. The head word lives in a
// registered output stage; the RAM holds everything behind it.
module burst_framer_fifo #(
  parameter int unsigned WIDTH      = 33,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  push,
  input  logic [WIDTH-1:0]      push_data,
  input  logic                  pop,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  empty,
  output logic [ADDR_WIDTH:0]   level
);

  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam int unsigned CW    = ADDR_WIDTH + 1;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;
  logic [CW-1:0]         mem_cnt;

  logic pop_c;
  logic load_c;
  logic mem_empty_c;
  logic mem_rd_c;
  logic mem_wr_c;
  logic bypass_c;

  // Output stage reloads when empty or when its word leaves this cycle.
  always_comb begin
    pop_c       = pop & out_valid;
    load_c      = ~out_valid | pop_c;
    mem_empty_c = (mem_cnt == '0);
    mem_rd_c    = load_c & ~mem_empty_c;
    bypass_c    = load_c & mem_empty_c & push;
    mem_wr_c    = push & ~bypass_c;
  end

  always_ff @(posedge aclk) begin
    if (mem_wr_c) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      mem_cnt   <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      empty     <= 1'b1;
      level     <= '0;
    end else begin
      if (mem_wr_c) begin
        wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      end
      if (mem_rd_c) begin
        rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
      end
      mem_cnt <= mem_cnt + CW'(mem_wr_c) - CW'(mem_rd_c);
      level   <= level + CW'(push) - CW'(pop_c);

      if (load_c) begin
        if (mem_rd_c) begin
          out_data  <= mem[rd_ptr];
          out_valid <= 1'b1;
          empty     <= 1'b0;
        end else if (bypass_c) begin
          out_data  <= push_data;
          out_valid <= 1'b1;
          empty     <= 1'b0;
        end else begin
          out_valid <= 1'b0;
          empty     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/axis_burst_framer.sv
// Frames each contiguous tvalid burst from the ADC stage as header + samples
// with tlast on the final word; overflow truncates or drops whole bursts.
module axis_burst_framer
  import axis_burst_framer_pkg::*;
#(
  parameter int unsigned FIFO_ADDR_WIDTH = 10,
  parameter logic [7:0]  HEADER_MAGIC    = 8'hA5
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic                       s_axis_tvalid,
  input  logic [31:0]                s_axis_tdata,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tvalid,
  output logic [31:0]                m_axis_tdata,
  output logic                       m_axis_tlast,
  output logic [15:0]                sts_lost,
  output logic [FIFO_ADDR_WIDTH:0]   sts_level
);

  localparam int unsigned DEPTH = 2 ** FIFO_ADDR_WIDTH;
  localparam int unsigned LW    = FIFO_ADDR_WIDTH + 1;

  logic [1:0]            state_q;
  logic [1:0]            state_nxt;
  logic [DATA_WIDTH-1:0] dly_q;
  logic [DATA_WIDTH-1:0] dly_nxt;
  logic [SEQ_WIDTH-1:0]  seq_q;
  logic [SEQ_WIDTH-1:0]  seq_nxt;
  logic [LOST_WIDTH-1:0] lost_q;
  logic [LOST_WIDTH-1:0] lost_nxt;
  logic [LOST_WIDTH-1:0] lost_sat_c;
  logic                  lost_flag_q;
  logic                  lost_flag_nxt;

  logic                  push_c;
  fifo_word_t            push_word_c;
  fifo_word_t            out_word;
  logic                  fifo_valid;
  logic                  fifo_empty;
  logic [LW-1:0]         fifo_level;
  logic [LW-1:0]         free_c;
  logic                  free_ge2_c;

  // Free space uses the registered level; a same-cycle pop is not credited.
  always_comb begin
    free_c     = LW'(DEPTH) - fifo_level;
    free_ge2_c = (free_c >= LW'(2));
    lost_sat_c = (lost_q == '1) ? lost_q : lost_q + LOST_WIDTH'(1);
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      dly_q       <= '0;
      seq_q       <= '0;
      lost_q      <= '0;
      lost_flag_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      dly_q       <= dly_nxt;
      seq_q       <= seq_nxt;
      lost_q      <= lost_nxt;
      lost_flag_q <= lost_flag_nxt;
    end
  end

  // One push per cycle at most: the delay register lets the final sample
  // carry tlast once the burst is seen to end.
  always_comb begin
    state_nxt     = state_q;
    dly_nxt       = dly_q;
    seq_nxt       = seq_q;
    lost_nxt      = lost_q;
    lost_flag_nxt = lost_flag_q;
    push_c        = 1'b0;
    push_word_c   = '0;

    case (state_q)
      ST_IDLE: begin
        if (s_axis_tvalid) begin
          seq_nxt = seq_q + SEQ_WIDTH'(1);
          if (free_ge2_c) begin
            push_c           = 1'b1;
            push_word_c.data = build_header(HEADER_MAGIC, lost_flag_q, seq_q);
            dly_nxt          = s_axis_tdata;
            lost_flag_nxt    = 1'b0;
            state_nxt        = ST_BURST;
          end else begin
            lost_nxt      = lost_sat_c;
            lost_flag_nxt = 1'b1;
            state_nxt     = ST_DROP;
          end
        end
      end

      ST_BURST: begin
        push_c           = 1'b1;
        push_word_c.data = dly_q;
        if (!s_axis_tvalid) begin
          push_word_c.last = 1'b1;
          state_nxt        = ST_IDLE;
        end else if (free_ge2_c) begin
          dly_nxt = s_axis_tdata;
        end else begin
          // Last free slot closes the frame so no header is left open.
          push_word_c.last = 1'b1;
          lost_nxt         = lost_sat_c;
          lost_flag_nxt    = 1'b1;
          state_nxt        = ST_DROP;
        end
      end

      ST_DROP: begin
        if (!s_axis_tvalid) begin
          state_nxt = ST_IDLE;
        end
      end

      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  burst_framer_fifo #(
    .WIDTH      (FIFO_WORD_WIDTH),
    .ADDR_WIDTH (FIFO_ADDR_WIDTH)
  ) u_fifo (
    .aclk      (aclk),
    .areset    (areset),
    .push      (push_c),
    .push_data (push_word_c),
    .pop       (m_axis_tready & ~fifo_empty),
    .out_valid (fifo_valid),
    .out_data  (out_word),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign m_axis_tvalid = fifo_valid;
  assign m_axis_tdata  = out_word.data;
  assign m_axis_tlast  = out_word.last;
  assign sts_lost      = lost_q;
  assign sts_level     = fifo_level;

endmodule

// File: doc/axis_burst_framer.md
# axis_burst_framer

Packetizes the triggered ADC sample stream into AXI4-Stream frames for the DMA/writer stage. It sits directly downstream of the triggered ADC block, whose output carries `tvalid` with no `tready`; each contiguous run of `tvalid` is one burst. Each burst becomes one frame: one header word, then the samples, with `tlast` on the final word. An internal FIFO absorbs downstream backpressure. Overflow is handled without ever leaving a frame unterminated.

## Interface
- `FIFO_ADDR_WIDTH`, 10: FIFO depth is 2^FIFO_ADDR_WIDTH words, 33 bits wide (data + last).
- `HEADER_MAGIC`, 8'hA5: value of header bits [31:24].
- `aclk` in 1: single clock; all logic is rising-edge.
- `areset` in 1: reset, synchronous, active-high.
- `s_axis_tvalid` in 1: burst qualifier from the ADC stage; no `tready` is returned.
- `s_axis_tdata` in 32: sample word {ch_b[15:0], ch_a[15:0]}, passed through unmodified.
- `m_axis_tready` in 1: downstream ready.
- `m_axis_tvalid` out 1: FIFO not empty.
- `m_axis_tdata` out 32: header or sample word.
- `m_axis_tlast` out 1: last word of the frame.
- `sts_lost` out 16: count of dropped plus truncated bursts; saturates at 16'hFFFF.
- `sts_level` out FIFO_ADDR_WIDTH+1: current FIFO occupancy.

## Operation
**Header word**
- [31:24] = HEADER_MAGIC.
- [23] = `lost_flag`, meaning the previous burst was truncated or dropped.
- [22:16] = 0.
- [15:0] = `seq`.

**Counters and flags**
- `seq` increments on every burst start detected in IDLE, including dropped bursts. It wraps at 16 bits.
- `free` = depth − level, sampled at the start of the cycle. A same-cycle pop is not credited.

**Write-side FSM**
- IDLE, `s_axis_tvalid`=1:
  - If `free`≥2: push header, latch the sample into the 1-deep delay register, clear `lost_flag`, go to BURST.
  - Else: `sts_lost`++, set `lost_flag`, go to DROP.
- BURST, `s_axis_tvalid`=1:
  - If `free`≥2: push the delayed sample with last=0 and latch the new sample.
  - If `free`==1: push the delayed sample with last=1, `sts_lost`++, set `lost_flag`, go to DROP.
- BURST, `s_axis_tvalid`=0: push the delayed sample with last=1, go to IDLE.
- DROP: discard input while `s_axis_tvalid`=1; go to IDLE when it is 0.

**Guarantees**
- At most one push per cycle, so a 1-cycle gap between bursts is sustained with no loss.
- Every header is eventually followed by a word with last=1.

**Read side**
- First-word-fall-through FIFO.
- Pop when `m_axis_tvalid` && `m_axis_tready`.
- Output data and last are stable while stalled.

## Timing
- Reset: all outputs 0. FSM to IDLE, FIFO flushed, `seq`/`sts_lost`/`lost_flag` cleared.
- Reset mid-burst: the frame in progress is discarded. If `s_axis_tvalid`=1 in the first cycle after reset, it is a new burst start (partial burst framed, seq 0).
- Latency into an empty FIFO with `m_axis_tready`=1:
  - Header is visible on `m_axis` in cycle t+1 for a burst start at cycle t.
  - Sample k accepted in cycle t+k is visible in cycle t+k+2.
- Last sample: pushed in the first cycle with `s_axis_tvalid`=0, visible one cycle later.
- Simultaneous push and pop when full: cannot occur, because the `free`≥1 invariant holds at every push.
- Simultaneous burst end and new start: needs ≥1 low cycle, which the upstream stage always produces.
- `sts_lost` and `sts_level` are registered and update the cycle after the event.

## Structure
- Package `axis_burst_framer_pkg`:
  - FSM state enum (IDLE, BURST, DROP).
  - Header field positions.
  - `SEQ_WIDTH`=16, `LOST_WIDTH`=16.
- Sub-module `burst_framer_fifo`: synchronous FWFT FIFO.
  - Parameterised width/depth.
  - Push, pop, level, empty.
  - Registered outputs.
- Top module holds the FSM, delay register, header builder and status counters.

## Test plan
- Single 16-sample burst, `m_axis_tready`=1 → frame A5000000, samples 1..16, `tlast` on sample 16, `sts_lost`=0.
- Two 16-sample bursts separated by one low cycle → headers A5000000 and A5000001, 34 words total, no loss.
- FIFO_ADDR_WIDTH=4, `m_axis_tready`=0, 32-sample burst → header + 15 samples with `tlast` on sample 15, `sts_lost`=1. Then drain, send a new burst → header A5800001.
- FIFO left full (`free`<2) at burst start → no words pushed, `sts_lost`++. The following burst header has bit 23 set and `seq` skipped by one.
- Random `m_axis_tready` (50%) over 100 bursts of random length 1..64 → scoreboard matches, every header paired with one `tlast`.
- `areset` asserted mid-burst for 1 cycle with `s_axis_tvalid` held high → FIFO empty, outputs 0. Next frame header A5000000 contains only post-reset samples.
